// File: rtl/ctrl_pkg.sv
// Shared definitions for the pipelined control unit: opcode map, ALU op
// codes, control-bundle field offsets and the sequencing FSM encoding.
package ctrl_pkg;

    // Opcode map
    localparam int OP_NOP  = 0;
    localparam int OP_SETC = 1;
    localparam int OP_CLRC = 2;
    localparam int OP_NOT  = 3;
    localparam int OP_INC  = 4;
    localparam int OP_DEC  = 5;
    localparam int OP_IN   = 6;
    localparam int OP_OUT  = 7;
    localparam int OP_PUSH = 8;
    localparam int OP_POP  = 9;
    localparam int OP_LDD  = 10;
    localparam int OP_POPD = 11;   // pop without register write-back
    localparam int OP_STD  = 12;
    localparam int OP_LDM  = 14;
    localparam int OP_JT1  = 16;
    localparam int OP_JT2  = 17;
    localparam int OP_JT3  = 18;
    localparam int OP_JMP  = 19;
    localparam int OP_CALL = 20;
    localparam int OP_RET  = 21;
    localparam int OP_RETI = 22;
    localparam int OP_MOV  = 24;
    localparam int OP_ADD  = 25;
    localparam int OP_SUB  = 26;
    localparam int OP_AND  = 28;
    localparam int OP_OR   = 29;
    localparam int OP_SHL  = 30;
    localparam int OP_SHR  = 31;

    // ALU operation codes
    localparam int ALU_NOP  = 0;
    localparam int ALU_NOT  = 1;
    localparam int ALU_INC  = 2;
    localparam int ALU_DEC  = 3;
    localparam int ALU_MOV  = 4;
    localparam int ALU_ADD  = 5;
    localparam int ALU_SUB  = 6;
    localparam int ALU_AND  = 7;
    localparam int ALU_OR   = 8;
    localparam int ALU_SHL  = 9;
    localparam int ALU_SHR  = 10;
    localparam int ALU_SETC = 11;
    localparam int ALU_CLRC = 12;
    localparam int ALU_MEM  = 13;
    localparam int ALU_LDM  = 14;

    // Flag-field bit offsets, relative to the top of the alu_op field
    localparam int FB_MEM_READ  = 0;
    localparam int FB_MEM_WRITE = 1;
    localparam int FB_WB        = 2;
    localparam int FB_PUSH      = 3;
    localparam int FB_POP       = 4;
    localparam int FB_IN_PORT   = 5;
    localparam int FB_OUT_PORT  = 6;
    localparam int FB_ONE_OP    = 7;
    localparam int FB_JUMP_TYPE = 8;   // two bits
    localparam int FB_PC_PUSH   = 10;
    localparam int FB_PC_POP    = 11;
    localparam int FB_FLAG_POP  = 12;
    localparam int CTRL_FLAG_W  = 13;

    localparam int ALU_OP_W_DEF = 4;
    localparam int CTRL_W       = ALU_OP_W_DEF + CTRL_FLAG_W;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_IMM   = 3'd1,
        ST_DJ    = 3'd2,
        ST_CALL1 = 3'd3,
        ST_CALL2 = 3'd4,
        ST_RET1  = 3'd5,
        ST_RET2  = 3'd6,
        ST_RETI0 = 3'd7
    } state_t;

    // CALL/RET sequences must finish even when a flush arrives mid-way
    function automatic logic seq_locked(state_t s);
        return (s == ST_CALL1) || (s == ST_CALL2) || (s == ST_RET1) ||
               (s == ST_RET2)  || (s == ST_RETI0);
    endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational opcode -> control bundle mapping.
module ctrl_decoder
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 5,
    parameter int ALU_OP_W = 4
) (
    input  logic [OPCODE_W-1:0]             i_opcode,
    output logic [ALU_OP_W+CTRL_FLAG_W-1:0] o_bundle,
    output logic                            o_is_imm
);

    logic [ALU_OP_W-1:0] w_alu;
    logic                w_mem_read, w_mem_write, w_wb, w_push, w_pop;
    logic                w_in_port, w_out_port, w_one_op;
    logic [1:0]          w_jump_type;

    // Field decode; anything not listed stays an all-zero NOP
    always_comb begin
        w_alu       = ALU_OP_W'(ALU_NOP);
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_in_port   = 1'b0;
        w_out_port  = 1'b0;
        w_one_op    = 1'b0;
        w_jump_type = 2'd0;
        o_is_imm    = 1'b0;
        case (int'(i_opcode))
            OP_SETC: w_alu = ALU_OP_W'(ALU_SETC);
            OP_CLRC: w_alu = ALU_OP_W'(ALU_CLRC);
            OP_NOT:  begin w_alu = ALU_OP_W'(ALU_NOT); w_one_op = 1'b1; end
            OP_INC:  begin w_alu = ALU_OP_W'(ALU_INC); w_one_op = 1'b1; end
            OP_DEC:  begin w_alu = ALU_OP_W'(ALU_DEC); w_one_op = 1'b1; end
            OP_IN:   w_in_port = 1'b1;
            OP_OUT:  w_out_port = 1'b1;
            OP_PUSH: begin w_push = 1'b1; w_alu = ALU_OP_W'(ALU_MEM); end
            OP_POP:  begin w_pop = 1'b1; w_mem_read = 1'b1; w_alu = ALU_OP_W'(ALU_MEM); end
            OP_LDD:  begin w_mem_read = 1'b1; w_alu = ALU_OP_W'(ALU_MEM); end
            OP_POPD: begin w_pop = 1'b1; w_alu = ALU_OP_W'(ALU_MEM); end
            OP_STD:  begin w_mem_write = 1'b1; w_alu = ALU_OP_W'(ALU_MEM); end
            OP_LDM:  begin w_alu = ALU_OP_W'(ALU_LDM); o_is_imm = 1'b1; end
            OP_MOV:  w_alu = ALU_OP_W'(ALU_MOV);
            OP_ADD:  w_alu = ALU_OP_W'(ALU_ADD);
            OP_SUB:  w_alu = ALU_OP_W'(ALU_SUB);
            OP_AND:  w_alu = ALU_OP_W'(ALU_AND);
            OP_OR:   w_alu = ALU_OP_W'(ALU_OR);
            OP_SHL:  begin w_alu = ALU_OP_W'(ALU_SHL); o_is_imm = 1'b1; end
            OP_SHR:  begin w_alu = ALU_OP_W'(ALU_SHR); o_is_imm = 1'b1; end
            OP_JT1:  w_jump_type = 2'd1;
            OP_JT2:  w_jump_type = 2'd2;
            OP_JT3:  w_jump_type = 2'd3;
            default: ;
        endcase
    end

    assign w_wb = ((w_alu != '0) || w_mem_read) && !w_mem_write && !w_push &&
                  (w_alu != ALU_OP_W'(ALU_SETC)) && (w_alu != ALU_OP_W'(ALU_CLRC)) &&
                  (int'(i_opcode) != OP_POPD);

    assign o_bundle = {1'b0, 1'b0, 1'b0, w_jump_type, w_one_op, w_out_port, w_in_port,
                       w_pop, w_push, w_wb, w_mem_write, w_mem_read, w_alu};

endmodule

// File: rtl/control_pipe_unit.sv
// Pipelined control unit: decode, CALL/RET/immediate sequencing FSM and the
// control-bundle register chain with stall bubbles and partial flush.
//
//  state  | meaning
//  IDLE   | decoding normal instruction words
//  IMM    | word in decode is immediate data, issue NOP
//  DJ     | bubble after an unconditional jump
//  CALL1  | first push of return PC, fetch held
//  CALL2  | second push of return PC, direct jump
//  RETI0  | pop flags, fetch held
//  RET1   | first pop of return PC, fetch held
//  RET2   | second pop of return PC, direct jump
module control_pipe_unit
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W    = 5,
    parameter int STAGES      = 4,
    parameter int FLUSH_DEPTH = 2,
    parameter int ALU_OP_W    = ALU_OP_W_DEF
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [OPCODE_W-1:0]                   opcode,
    input  logic                                  stall,
    input  logic                                  jump_occured,
    output logic [STAGES*(ALU_OP_W+CTRL_FLAG_W)-1:0] ctrl_pipe,
    output logic                                  fetch_hold,
    output logic                                  imm_next,
    output logic                                  direct_jump
);

    localparam int BUNDLE_W = ALU_OP_W + CTRL_FLAG_W;
    localparam logic [BUNDLE_W-1:0] B_ONE = BUNDLE_W'(1);
    localparam logic [BUNDLE_W-1:0] BND_PUSH_PC =
        BUNDLE_W'(ALU_MEM) | (B_ONE << (ALU_OP_W + FB_PUSH)) | (B_ONE << (ALU_OP_W + FB_PC_PUSH));
    localparam logic [BUNDLE_W-1:0] BND_POP_PC =
        (B_ONE << (ALU_OP_W + FB_POP)) | (B_ONE << (ALU_OP_W + FB_PC_POP)) |
        (B_ONE << (ALU_OP_W + FB_MEM_READ));
    localparam logic [BUNDLE_W-1:0] BND_FLAG_POP =
        (B_ONE << (ALU_OP_W + FB_POP)) | (B_ONE << (ALU_OP_W + FB_FLAG_POP)) |
        (B_ONE << (ALU_OP_W + FB_MEM_READ));

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BUNDLE_W-1:0] r_bundle [STAGES];
    logic [BUNDLE_W-1:0] w_dec;
    logic [BUNDLE_W-1:0] w_issue;
    logic                w_dec_imm;

    ctrl_decoder #(
        .OPCODE_W (OPCODE_W),
        .ALU_OP_W (ALU_OP_W)
    ) u_decoder (
        .i_opcode (opcode),
        .o_bundle (w_dec),
        .o_is_imm (w_dec_imm)
    );

    // Next state and the bundle to load into stage 0 (bundle shown during state S is S's work)
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = '0;
        case (r_state)
            ST_IDLE: begin
                w_issue = w_dec;
                case (int'(opcode))
                    OP_JMP:  w_state_nxt = ST_DJ;
                    OP_CALL: begin w_state_nxt = ST_CALL1; w_issue = BND_PUSH_PC;  end
                    OP_RET:  begin w_state_nxt = ST_RET1;  w_issue = BND_POP_PC;   end
                    OP_RETI: begin w_state_nxt = ST_RETI0; w_issue = BND_FLAG_POP; end
                    default: if (w_dec_imm) w_state_nxt = ST_IMM;
                endcase
            end
            ST_CALL1: begin w_state_nxt = ST_CALL2; w_issue = BND_PUSH_PC; end
            ST_RETI0: begin w_state_nxt = ST_RET1;  w_issue = BND_POP_PC;  end
            ST_RET1:  begin w_state_nxt = ST_RET2;  w_issue = BND_POP_PC;  end
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (jump_occured && !seq_locked(r_state)) begin
            w_state_nxt = ST_IDLE;
        end
    end

    // State register and bundle chain; stall holds stage 0 and bubbles stage 1
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            for (int k = 0; k < STAGES; k++) begin
                r_bundle[k] <= '0;
            end
        end else begin
            if (!stall) begin
                r_state <= w_state_nxt;
            end
            if (jump_occured) begin
                r_bundle[0] <= '0;
            end else if (!stall) begin
                r_bundle[0] <= w_issue;
            end
            for (int k = 1; k < STAGES; k++) begin
                if ((jump_occured && (k < FLUSH_DEPTH)) || (stall && (k == 1))) begin
                    r_bundle[k] <= '0;
                end else begin
                    r_bundle[k] <= r_bundle[k-1];
                end
            end
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_pack
        assign ctrl_pipe[g*BUNDLE_W +: BUNDLE_W] = r_bundle[g];
    end

    assign fetch_hold  = (r_state == ST_CALL1) || (r_state == ST_RET1) ||
                         (r_state == ST_RETI0) || (r_state == ST_RET2);
    assign imm_next    = (r_state == ST_IMM);
    assign direct_jump = !rst && !stall &&
                         (((r_state == ST_IDLE) && (int'(opcode) == OP_JMP)) ||
                          (r_state == ST_CALL2) || (r_state == ST_RET2));

endmodule

// File: tb/tb_control_pipe_unit.sv
// Directed bench for control_pipe_unit with hand-computed expected bundles.
module tb_control_pipe_unit;

    localparam int ST = 4;
    localparam int CW = 17;
    localparam int PW = ST * CW;

    logic          clk = 1'b0;
    logic          rst, stall, jump_occured;
    logic [4:0]    opcode;
    logic [PW-1:0] ctrl_pipe;
    logic          fetch_hold, imm_next, direct_jump;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    control_pipe_unit #(
        .OPCODE_W    (5),
        .STAGES      (ST),
        .FLUSH_DEPTH (2),
        .ALU_OP_W    (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .stall        (stall),
        .jump_occured (jump_occured),
        .ctrl_pipe    (ctrl_pipe),
        .fetch_hold   (fetch_hold),
        .imm_next     (imm_next),
        .direct_jump  (direct_jump)
    );

    function automatic logic [CW-1:0] bnd(input int k);
        return ctrl_pipe[k*CW +: CW];
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkp(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; jump_occured = 1'b0; opcode = 5'd0;
        tick();
        // stream of ADDs, then reset mid-stream
        rst = 1'b0; opcode = 5'd25;
        tick(); tick(); tick();
        chkb("pre_rst_b2", bnd(2), 17'h45);
        rst = 1'b1;
        tick(); tick();
        chkp("rst_pipe", ctrl_pipe, '0);
        chk1("rst_fetch_hold", fetch_hold, 1'b0);
        chk1("rst_direct_jump", direct_jump, 1'b0);
        chk1("rst_imm_next", imm_next, 1'b0);
        rst = 1'b0;
        tick();
        chkb("rel_b0_add", bnd(0), 17'h45);
        chkb("rel_b1_zero", bnd(1), 17'h0);

        // ADD, STD, PUSH, SETC travelling to stage 3
        opcode = 5'd12; tick();
        opcode = 5'd8;  tick();
        opcode = 5'd1;  tick();
        chkb("b3_add", bnd(3), 17'h45);
        opcode = 5'd0;
        tick(); chkb("b3_std", bnd(3), 17'h2D);
        tick(); chkb("b3_push", bnd(3), 17'h8D);
        tick(); chkb("b3_setc", bnd(3), 17'h0B);

        // LDM then immediate data that looks like ADD
        opcode = 5'd14; tick();
        chkb("ldm_b0", bnd(0), 17'h4E);
        chk1("ldm_imm_next", imm_next, 1'b1);
        opcode = 5'd25; tick();
        chkb("imm_b0_nop", bnd(0), 17'h0);
        chk1("imm_next_clear", imm_next, 1'b0);
        chkb("imm_b1_ldm", bnd(1), 17'h4E);

        // CALL sequence
        opcode = 5'd20; tick();
        chk1("call1_hold", fetch_hold, 1'b1);
        chkb("call1_b0", bnd(0), 17'h408D);
        chk1("call1_dj", direct_jump, 1'b0);
        opcode = 5'd0; tick();
        chk1("call2_hold", fetch_hold, 1'b0);
        chkb("call2_b0", bnd(0), 17'h408D);
        chkb("call2_b1", bnd(1), 17'h408D);
        chk1("call2_dj", direct_jump, 1'b1);
        tick();
        chk1("call_done_dj", direct_jump, 1'b0);
        chk1("call_done_hold", fetch_hold, 1'b0);
        chkb("call_done_b0", bnd(0), 17'h0);

        // RETI sequence: flag_pop, pc_pop, pc_pop
        opcode = 5'd22; tick();
        chk1("reti0_flag_pop", ctrl_pipe[16], 1'b1);
        chk1("reti0_mem_read", ctrl_pipe[4], 1'b1);
        chk1("reti0_hold", fetch_hold, 1'b1);
        opcode = 5'd0; tick();
        chk1("ret1_pc_pop", ctrl_pipe[15], 1'b1);
        chk1("ret1_flag_pop", ctrl_pipe[16], 1'b0);
        chk1("ret1_mem_read", ctrl_pipe[4], 1'b1);
        chk1("ret1_hold", fetch_hold, 1'b1);
        tick();
        chk1("ret2_pc_pop", ctrl_pipe[15], 1'b1);
        chk1("ret2_mem_read", ctrl_pipe[4], 1'b1);
        chk1("ret2_hold", fetch_hold, 1'b1);
        chk1("ret2_dj", direct_jump, 1'b1);
        tick();
        chk1("ret_done_hold", fetch_hold, 1'b0);
        chk1("ret_done_dj", direct_jump, 1'b0);

        // JMP: direct_jump suppressed by stall, then DJ bubble
        opcode = 5'd19; stall = 1'b1; #1;
        chk1("jmp_stalled_dj", direct_jump, 1'b0);
        stall = 1'b0; #1;
        chk1("jmp_dj", direct_jump, 1'b1);
        tick();
        chk1("dj_state_dj", direct_jump, 1'b0);
        chkb("jmp_b0_nop", bnd(0), 17'h0);
        opcode = 5'd25; tick();
        chkb("dj_bubble_b0", bnd(0), 17'h0);

        // flush on a pipeline full of ADDs
        tick(); tick(); tick(); tick();
        chkp("full_add", ctrl_pipe, {17'h45, 17'h45, 17'h45, 17'h45});
        jump_occured = 1'b1; tick();
        jump_occured = 1'b0;
        chkp("flush_pipe", ctrl_pipe, {17'h45, 17'h45, 17'h0, 17'h0});

        // stall alone: stage 0 holds, stage 1 bubble, stage 2 advances
        tick(); tick(); tick(); tick();
        opcode = 5'd12; stall = 1'b1; tick();
        chkb("stall_b0_hold", bnd(0), 17'h45);
        chkb("stall_b1_bubble", bnd(1), 17'h0);
        chkb("stall_b2_adv", bnd(2), 17'h45);
        stall = 1'b0; opcode = 5'd25;
        tick(); tick(); tick(); tick();

        // stall + flush while in IMM
        opcode = 5'd14; tick();
        chk1("pre_sf_imm", imm_next, 1'b1);
        stall = 1'b1; jump_occured = 1'b1; opcode = 5'd25; tick();
        chkp("sf_pipe", ctrl_pipe, {17'h45, 17'h45, 17'h0, 17'h0});
        chk1("sf_fsm_held", imm_next, 1'b1);
        jump_occured = 1'b0; tick();
        chkp("stall_only_pipe", ctrl_pipe, {17'h45, 17'h0, 17'h0, 17'h0});
        chk1("stall_fsm_held", imm_next, 1'b1);
        stall = 1'b0; tick();
        chkb("after_imm_b0", bnd(0), 17'h0);
        chk1("after_imm_next", imm_next, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/control_pipe_unit.md
Name: control_pipe_unit

Overview:
Parametrised successor to the single-issue control unit. It decodes the 5-bit opcode into a control bundle and carries that bundle down a parametrised chain of pipeline registers, one register per stage. All logic is single-edge, on the rising edge only. It adds several things the old unit lacked:
- synchronous reset;
- stall with bubble insertion;
- flush of a configurable depth;
- a sequencing FSM for multi-word and multi-cycle instructions (LDM/SHL/SHR immediate, JMP, CALL, RET, RETI).

It sits between fetch/decode and the datapath stage registers.

Parameters:
OPCODE_W, 5, opcode width
STAGES, 4, number of bundle registers after decode (ctrl index 0 = EX ... STAGES-1 = WB)
FLUSH_DEPTH, 2, number of youngest bundle registers cleared on jump_occured (1..STAGES)
ALU_OP_W, 4, ALU operation field width

Ports:
clk  in  1  system clock, rising edge only
rst  in  1  synchronous, active-high reset
opcode  in  OPCODE_W  opcode of the instruction word currently in decode
stall  in  1  hazard stall from the hazard unit
jump_occured  in  1  branch/jump resolved taken
ctrl_pipe  out  STAGES*CTRL_W  flattened bundles; bundle k occupies bits [k*CTRL_W +: CTRL_W]
fetch_hold  out  1  FSM busy; fetch must not advance PC (CALL/RET sequencing)
imm_next  out  1  next fetched word is immediate data, not an opcode
direct_jump  out  1  unconditional-jump pulse for the PC mux

Behaviour:
Bundle layout, LSB first (CTRL_W = ALU_OP_W + 13):
- alu_op[ALU_OP_W]
- mem_read, mem_write, wb, push, pop, in_port, out_port, one_operand
- jump_type[2]
- pc_push, pc_pop, flag_pop

Reset: on rst=1 at a rising edge:
- all bundle registers and outputs go to 0;
- FSM goes to IDLE.

Reset has priority over stall and flush.

Decode. The opcode map is unchanged:
- 1 SETC → alu 11; 2 CLRC → alu 12
- 3 NOT / 4 INC / 5 DEC → alu 1/2/3, one_operand=1
- 6 IN, 7 OUT
- 8 PUSH → push, alu 13
- 9 POP → pop, mem_read, alu 13
- 10 LDD → mem_read, alu 13
- 11 → pop, alu 13, wb=0
- 12 STD → mem_write, alu 13
- 14 LDM → alu 14, imm
- 24 MOV → 4; 25 ADD → 5; 26 SUB → 6; 28 AND → 7; 29 OR → 8
- 30 SHL → 9, imm; 31 SHR → 10, imm
- 16/17/18 → jump_type 1/2/3
- 19 JMP; 20 CALL; 21 RET; 22 RETI
- anything else → NOP (all-zero bundle)

wb rule: wb = (alu_op≠0 or mem_read), and not mem_write, not push, alu_op∉{11,12}, opcode≠11.

Latency: an opcode sampled at edge n appears in bundle 0 after edge n. Bundle k equals bundle k-1 of the previous cycle.

FSM states and transitions:
- IDLE:
  - imm opcode → IMM; imm_next=1; the bundle is issued.
  - JMP → DJ; direct_jump=1 for one cycle.
  - CALL → CALL1.
  - RET → RET1.
  - RETI → RETI0.
- IMM: the decode word is data; bundle 0 = NOP; → IDLE.
- DJ: bubble; direct_jump=0; → IDLE.
- CALL1: issue push + pc_push, alu 13, fetch_hold=1; → CALL2.
- CALL2: second push + pc_push; direct_jump=1; → IDLE.
- RET1: pop + pc_pop + mem_read, fetch_hold=1; → RET2.
- RET2: second pop + pc_pop + mem_read; direct_jump=1; → IDLE.
- RETI0: pop + flag_pop + mem_read, fetch_hold=1; → RET1.

fetch_hold is 1 in CALL1, RET1, RETI0 and RET2.

Stall:
- FSM state and bundle 0 hold their value.
- Bundle 1 receives all zeros (a bubble).
- Bundles ≥2 advance.
- direct_jump is suppressed while stalled.

Flush (jump_occured=1):
- Bundles 0..FLUSH_DEPTH-1 load zeros.
- Bundles ≥ FLUSH_DEPTH advance.
- The FSM returns to IDLE unless it is in CALL1/CALL2/RET*, which complete.

Simultaneous stall and flush: flush wins for the flushed registers; the stall still holds the FSM.

Decomposition:
- Shared package ctrl_pkg holds:
  - opcode localparams (OP_NOP … OP_RETI);
  - ALU op codes 0..14;
  - bundle field offsets and CTRL_W;
  - FSM state encoding.
- One natural sub-module, ctrl_decoder: purely combinational opcode→bundle mapping.
- The pipeline chain and FSM stay in the top module.

Test Plan:
1. rst held 2 cycles mid-stream with opcode=25 → all ctrl_pipe=0, fetch_hold=0, direct_jump=0. First edge after release: bundle 0 alu=5, wb=1.
2. ADD, STD, PUSH, SETC on consecutive cycles → bundle 3 shows alu 5/wb=1, then mem_write=1/wb=0, then push=1/wb=0, then alu 11/wb=0, at edges n+4..n+7.
3. LDM then opcode bits =25 (immediate data) → bundle 0 alu=14, imm_next=1, then bundle 0 = 0 (data not decoded as ADD).
4. CALL → fetch_hold=1 for 1 cycle; two consecutive bundles with push=pc_push=1; direct_jump pulse on the second; back to IDLE.
5. RETI → bundle sequence flag_pop, pc_pop, pc_pop, each with mem_read=1; fetch_hold high for 3 cycles.
6. Pipeline full of ADDs:
   - jump_occured=1 with FLUSH_DEPTH=2 → bundles 0,1 zero, bundles 2,3 intact.
   - stall=1 same cycle → FSM held, bundle 1 zero.
